// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one word-aligned Avalon read/write per memory op; the raw aligned word is returned with the opcode and addr[1:0].
// Accept->done is 2+wait cycles and req_ready is high only in IDLE; waitrequest stalls until TIMEOUT_CYCLES, then err.
module mips_cpu_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic [31:0] bus_readdata,
  input  logic        bus_waitrequest,
  output logic        done,
  output logic [31:0] load_word,
  output logic [5:0]  load_opcode,
  output logic [1:0]  load_addr_lo,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_FAULT} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_is_load;
  logic [5:0]  r_op;
  logic [1:0]  r_lo;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_load_word;
  logic [5:0]  r_load_op;
  logic [1:0]  r_load_lo;

  logic        w_legal;
  logic        w_load;
  logic        w_misal;
  logic        w_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_finish;

  // Opcode decode: legality, alignment, lane enables and lane-replicated store data
  always_comb begin
    w_legal = 1'b0;
    w_load  = 1'b0;
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_opcode)
      6'b100000, 6'b100010, 6'b100100, 6'b100110: begin
        w_legal = 1'b1;
        w_load  = 1'b1;
      end
      6'b100001, 6'b100101: begin
        w_legal = 1'b1;
        w_load  = 1'b1;
        w_misal = req_addr[0];
      end
      6'b100011: begin
        w_legal = 1'b1;
        w_load  = 1'b1;
        w_misal = |req_addr[1:0];
      end
      6'b101000: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      6'b101001: begin
        w_legal = 1'b1;
        w_misal = req_addr[0];
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      6'b101011: begin
        w_legal = 1'b1;
        w_misal = |req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_ok = w_legal && !w_misal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_ok ? S_BUS : S_FAULT;
        end
      end
      S_BUS: begin
        bus_read  = r_is_load;
        bus_write = !r_is_load;
        if (!bus_waitrequest) begin
          w_next = S_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_next = S_FAULT;
        end
      end
      S_RESP: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_FAULT: begin
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Completion metadata is written on entry to RESP/FAULT so it is valid alongside done/err
  assign w_finish = (w_next == S_RESP) || (w_next == S_FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 8'd0;
      r_is_load   <= 1'b0;
      r_op        <= 6'd0;
      r_lo        <= 2'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_load_word <= 32'd0;
      r_load_op   <= 6'd0;
      r_load_lo   <= 2'd0;
    end else begin
      if (r_state == S_IDLE && req_valid && w_ok) begin
        r_cnt     <= 8'd0;
        r_is_load <= w_load;
        r_op      <= req_opcode;
        r_lo      <= req_addr[1:0];
        r_addr    <= {req_addr[31:2], 2'b00};
        r_wdata   <= w_wdata;
        r_be      <= w_be;
      end
      if (r_state == S_BUS) begin
        if (bus_waitrequest) begin
          r_cnt <= r_cnt + 8'd1;
        end else if (r_is_load) begin
          r_load_word <= bus_readdata;
        end
      end
      if (w_finish) begin
        r_load_op <= (r_state == S_IDLE) ? req_opcode : r_op;
        r_load_lo <= (r_state == S_IDLE) ? req_addr[1:0] : r_lo;
      end
    end
  end

  assign bus_address    = r_addr;
  assign bus_byteenable = r_be;
  assign bus_writedata  = r_wdata;
  assign load_word      = r_load_word;
  assign load_opcode    = r_load_op;
  assign load_addr_lo   = r_load_lo;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Bench for mips_cpu_lsu: memory-backed Avalon slave with programmable wait states, scoreboard of completions.
module tb_mips_cpu_lsu;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;
  logic        done;
  logic [31:0] load_word;
  logic [5:0]  load_opcode;
  logic [1:0]  load_addr_lo;
  logic        err;

  mips_cpu_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest),
    .done(done), .load_word(load_word), .load_opcode(load_opcode),
    .load_addr_lo(load_addr_lo), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: 16-word memory indexed by addr[5:2]; garbage on readdata when not reading
  logic [31:0] mem [16];
  logic [31:0] mdl_mem [16];
  int slv_wait = 0;
  int slv_cnt = 0;

  assign bus_waitrequest = (bus_read | bus_write) && (slv_cnt < slv_wait);
  assign bus_readdata    = bus_read ? mem[bus_address[5:2]] : 32'hBADC0DE0;

  always @(posedge clk) begin
    if (bus_read | bus_write) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
    if (bus_write && !bus_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (bus_byteenable[b]) mem[bus_address[5:2]][8*b +: 8] = bus_writedata[8*b +: 8];
    end
  end

  typedef struct {
    logic        is_err;
    logic [31:0] word;
    logic [5:0]  op;
    logic [1:0]  lo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_lw = 32'd0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_read | bus_write) check_eq("rd_wr_excl", 32'(bus_read & bus_write), 32'd0);
      if (done | err) begin
        check_eq("done_err_excl", 32'(done & err), 32'd0);
        check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("err_kind", 32'(err), 32'(mon_e.is_err));
          check_eq("load_word", load_word, mon_e.word);
          check_eq("load_opcode", 32'(load_opcode), 32'(mon_e.op));
          check_eq("load_addr_lo", 32'(load_addr_lo), 32'(mon_e.lo));
        end
      end
    end
  end

  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                                output logic legal, output logic ld,
                                output logic [3:0] be, output logic [31:0] wdat);
    legal = 1'b1;
    ld    = 1'b1;
    be    = 4'hF;
    wdat  = wd;
    case (op)
      6'h20, 6'h22, 6'h24, 6'h26: ;
      6'h21, 6'h25: legal = (a[0] == 1'b0);
      6'h23: legal = (a[1:0] == 2'b00);
      6'h28: begin
        ld = 1'b0;
        case (a[1:0])
          2'd0: be = 4'h1;
          2'd1: be = 4'h2;
          2'd2: be = 4'h4;
          default: be = 4'h8;
        endcase
        wdat = {24'd0, wd[7:0]} * 32'h01010101;
      end
      6'h29: begin
        ld    = 1'b0;
        legal = (a[0] == 1'b0);
        be    = a[1] ? 4'hC : 4'h3;
        wdat  = {16'd0, wd[15:0]} * 32'h00010001;
      end
      6'h2B: begin
        ld    = 1'b0;
        legal = (a[1:0] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, input int waits);
    logic        legal, ld, tmo;
    logic [3:0]  be;
    logic [31:0] wdat;
    exp_t        e;
    int          idx, n, lat, strb;
    model(op, a, wd, legal, ld, be, wdat);
    tmo = legal && (waits >= TMO);
    idx = int'(a[5:2]);
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_wait", 32'(req_ready), 32'd1);
    if (legal && !tmo) begin
      if (ld) exp_lw = mdl_mem[idx];
      else for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[idx][8*b +: 8] = wdat[8*b +: 8];
    end
    e.is_err = !legal || tmo;
    e.word   = exp_lw;
    e.op     = op;
    e.lo     = a[1:0];
    sb_q.push_back(e);
    slv_wait   = waits;
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    // valid stays high with junk fields: must be ignored while busy
    req_opcode = 6'b111111;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    strb = 0;
    while (!(done || err) && lat < 20) begin
      if (bus_read | bus_write) begin
        strb++;
        check_eq("bus_address", bus_address, {a[31:2], 2'b00});
        check_eq("byteenable", 32'(bus_byteenable), 32'(be));
        check_eq("bus_read", 32'(bus_read), 32'(ld));
        if (!ld) check_eq("writedata", bus_writedata, wdat);
      end
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check_eq("latency", 32'(lat), !legal ? 32'd1 : (tmo ? 32'(TMO + 1) : 32'(2 + waits)));
    check_eq("strobe_cycles", 32'(strb), !legal ? 32'd0 : (tmo ? 32'(TMO) : 32'(waits + 1)));
  endtask

  logic [5:0] op_tab [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h28, 6'h29, 6'h2B, 6'h3F, 6'h2A};

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h0F1E2D3C ^ (32'(i) * 32'h11111111);
      mdl_mem[i] = mem[i];
    end
    mem[0]     = 32'hDEADBEEF;
    mdl_mem[0] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
    check_eq("rst_addr", bus_address, 32'd0);
    check_eq("rst_be_wd", {28'd0, bus_byteenable} | bus_writedata, 32'd0);
    check_eq("rst_load_word", load_word, 32'd0);
    check_eq("rst_meta", {24'd0, load_opcode, load_addr_lo}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(6'h23, 32'h0000_1000, 32'd0, 0);
    check_eq("lw_deadbeef", load_word, 32'hDEADBEEF);
    issue(6'h28, 32'h0000_2003, 32'h0000_00A5, 0);
    check_eq("sb_keeps_word", load_word, 32'hDEADBEEF);
    issue(6'h29, 32'h0000_2002, 32'h0000_1234, 3);
    issue(6'h23, 32'h0000_2000, 32'd0, 1);
    check_eq("lane_merge", load_word, 32'h1234BEEF);
    issue(6'h21, 32'h0000_3001, 32'd0, 0);
    issue(6'h3F, 32'h0000_3000, 32'd0, 0);
    issue(6'h23, 32'h0000_1004, 32'd0, 9);
    check_eq("tmo_keeps_word", load_word, 32'h1234BEEF);
    @(posedge clk); #1;
    check_eq("tmo_ready", 32'(req_ready), 32'd1);

    for (int k = 0; k < 60; k++) begin
      issue(op_tab[$urandom_range(0, 11)], 32'h1000 + 32'($urandom_range(0, 63)), $urandom,
            ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3));
    end

    // Reset while a read is stalled on the bus
    @(posedge clk); #1;
    slv_wait   = 100;
    req_valid  = 1'b1;
    req_opcode = 6'h23;
    req_addr   = 32'h0000_1008;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_read", 32'(bus_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_strobe", {30'd0, bus_read, bus_write}, 32'd0);
    check_eq("arst_done_err", {30'd0, done, err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_lw = 32'd0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_word", load_word, 32'd0);
    issue(6'h24, 32'h0000_1001, 32'd0, 2);

    @(posedge clk); #1;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
